// File: rtl/roboy_coms_pkg.sv
// Shared definitions for the roboy status link: frame layout, field offsets,
// CRC16 step function and receiver state encoding.
package roboy_coms_pkg;

  localparam logic [31:0] STATUS_FRAME_MAGICNUMBER = 32'h1CEB00DA;
  localparam int STATUS_FRAME_LENGTH = 28;
  localparam int MAGIC_NUMBER_LENGTH = 4;
  localparam int PAYLOAD_LENGTH      = STATUS_FRAME_LENGTH - MAGIC_NUMBER_LENGTH;
  localparam int CRC_COVERED_BYTES   = 22;

  // Payload byte offsets; multi-byte fields are MSB first.
  localparam int OFS_MOTOR_ID     = 0;
  localparam int OFS_CONTROL_MODE = 1;
  localparam int OFS_ENCODER0     = 2;
  localparam int OFS_ENCODER1     = 5;
  localparam int OFS_SETPOINT     = 8;
  localparam int OFS_DUTY         = 11;
  localparam int OFS_DISPLACEMENT = 14;
  localparam int OFS_CURRENT      = 17;
  localparam int OFS_COLOR        = 19;
  localparam int OFS_CRC          = 22;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'h8005;

  typedef logic [1:0] state_t;
  localparam state_t ST_HUNT    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_CHECK   = 2'd2;

  // x^16+x^15+x^2+1, data MSB first, no reflection.
  function automatic logic [15:0] nextCRC16_D8(input logic [7:0] data, input logic [15:0] crc);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_accumulator.sv
// Registered byte-wide CRC16 accumulator; init has priority over en.
module crc16_accumulator
  import roboy_coms_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= CRC16_INIT;
    else if (init) crc <= CRC16_INIT;
    else if (en)   crc <= nextCRC16_D8(data, crc);
  end

endmodule

// File: rtl/status_frame_receiver.sv
// Parses the UART byte stream into CRC-checked motor status frames and
// holds the fields of the most recent clean frame.
module status_frame_receiver
  import roboy_coms_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 50_000_000,
  parameter int BAUDRATE          = 2_000_000,
  parameter int GAP_TIMEOUT_BYTES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               abort,
  output logic               busy,
  output logic               frame_valid,
  output logic               crc_error,
  output logic               timeout_error,
  output logic [7:0]         motor_id,
  output logic [7:0]         control_mode,
  output logic signed [23:0] encoder0_position,
  output logic signed [23:0] encoder1_position,
  output logic signed [23:0] setpoint_actual,
  output logic signed [23:0] duty,
  output logic signed [23:0] displacement,
  output logic signed [15:0] current,
  output logic [23:0]        neopxl_color_actual,
  output logic [15:0]        good_count,
  output logic [15:0]        crc_err_count
);

  localparam int GAP_RELOAD = CLK_FREQ_HZ / BAUDRATE * 10 * GAP_TIMEOUT_BYTES;
  localparam int GAP_W      = $clog2(GAP_RELOAD + 1);

  state_t           state;
  // Only the three newest bytes are kept: the oldest of four is never compared.
  logic [23:0]      hunt_sr;
  logic [4:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       payload [PAYLOAD_LENGTH];
  logic [15:0]      crc;

  logic [31:0] hunt_next;
  logic        magic_hit;
  logic        payload_byte;
  logic        last_byte;
  logic        gap_expired;
  logic        crc_init;
  logic        crc_en;
  logic        crc_match;
  logic        check_now;

  always_comb begin
    hunt_next    = {hunt_sr, rx_data};
    magic_hit    = (state == ST_HUNT) && rx_valid && (hunt_next == STATUS_FRAME_MAGICNUMBER);
    payload_byte = (state == ST_PAYLOAD) && rx_valid && !abort;
    last_byte    = payload_byte && (byte_cnt == 5'(PAYLOAD_LENGTH - 1));
    gap_expired  = (state == ST_PAYLOAD) && !rx_valid && (gap_cnt == '0) && !abort;
    crc_init     = magic_hit;
    crc_en       = payload_byte && (byte_cnt < 5'(CRC_COVERED_BYTES));
    crc_match    = (crc == {payload[OFS_CRC], payload[OFS_CRC + 1]});
    check_now    = (state == ST_CHECK) && !abort;
  end

  assign busy = (state == ST_PAYLOAD) || (state == ST_CHECK);

  crc16_accumulator u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_en),
    .data    (rx_data),
    .crc     (crc)
  );

  // Frame sequencing: hunt, payload collection with gap watchdog, one-cycle check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HUNT;
      hunt_sr  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else if (abort) begin
      state    <= ST_HUNT;
      hunt_sr  <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_HUNT: begin
          if (magic_hit) begin
            state    <= ST_PAYLOAD;
            hunt_sr  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= GAP_W'(GAP_RELOAD);
          end else if (rx_valid) begin
            hunt_sr  <= hunt_next[23:0];
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            gap_cnt  <= GAP_W'(GAP_RELOAD);
            byte_cnt <= byte_cnt + 5'd1;
            if (last_byte) state <= ST_CHECK;
          end else if (gap_cnt == '0) begin
            state    <= ST_HUNT;
          end else begin
            gap_cnt  <= gap_cnt - 1'b1;
          end
        end
        ST_CHECK: state <= ST_HUNT;
        default:  state <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (payload_byte) payload[byte_cnt] <= rx_data;
  end

  // Result stage: pulses, counters and field load, one cycle after CHECK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid         <= 1'b0;
      crc_error           <= 1'b0;
      timeout_error       <= 1'b0;
      good_count          <= '0;
      crc_err_count       <= '0;
      motor_id            <= '0;
      control_mode        <= '0;
      encoder0_position   <= '0;
      encoder1_position   <= '0;
      setpoint_actual     <= '0;
      duty                <= '0;
      displacement        <= '0;
      current             <= '0;
      neopxl_color_actual <= '0;
    end else begin
      frame_valid   <= check_now && crc_match;
      crc_error     <= check_now && !crc_match;
      timeout_error <= gap_expired;
      if (check_now && crc_match) begin
        good_count          <= good_count + 16'd1;
        motor_id            <= payload[OFS_MOTOR_ID];
        control_mode        <= payload[OFS_CONTROL_MODE];
        encoder0_position   <= {payload[OFS_ENCODER0], payload[OFS_ENCODER0 + 1], payload[OFS_ENCODER0 + 2]};
        encoder1_position   <= {payload[OFS_ENCODER1], payload[OFS_ENCODER1 + 1], payload[OFS_ENCODER1 + 2]};
        setpoint_actual     <= {payload[OFS_SETPOINT], payload[OFS_SETPOINT + 1], payload[OFS_SETPOINT + 2]};
        duty                <= {payload[OFS_DUTY], payload[OFS_DUTY + 1], payload[OFS_DUTY + 2]};
        displacement        <= {payload[OFS_DISPLACEMENT], payload[OFS_DISPLACEMENT + 1],
                                payload[OFS_DISPLACEMENT + 2]};
        current             <= {payload[OFS_CURRENT], payload[OFS_CURRENT + 1]};
        neopxl_color_actual <= {payload[OFS_COLOR], payload[OFS_COLOR + 1], payload[OFS_COLOR + 2]};
      end
      if (check_now && !crc_match) crc_err_count <= crc_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_status_frame_receiver.sv
// Randomized self-checking bench for status_frame_receiver against a frame-level model.
module tb_status_frame_receiver;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               abort;
  logic               busy, frame_valid, crc_error, timeout_error;
  logic [7:0]         motor_id, control_mode;
  logic signed [23:0] encoder0_position, encoder1_position, setpoint_actual, duty, displacement;
  logic signed [15:0] current;
  logic [23:0]        neopxl_color_actual;
  logic [15:0]        good_count, crc_err_count;

  status_frame_receiver dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data), .abort(abort),
    .busy(busy), .frame_valid(frame_valid), .crc_error(crc_error), .timeout_error(timeout_error),
    .motor_id(motor_id), .control_mode(control_mode),
    .encoder0_position(encoder0_position), .encoder1_position(encoder1_position),
    .setpoint_actual(setpoint_actual), .duty(duty), .displacement(displacement),
    .current(current), .neopxl_color_actual(neopxl_color_actual),
    .good_count(good_count), .crc_err_count(crc_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last clean frame, expected counters, total clean frames ever.
  logic [7:0]  pl     [24];
  logic [7:0]  exp_pl [24];
  logic [15:0] exp_good, exp_crc;
  int          total_good = 0;

  // Pulse monitor.
  int n_fv = 0, n_ce = 0, n_to = 0, n_multi = 0;
  always @(negedge clk) begin
    if (frame_valid)   n_fv++;
    if (crc_error)     n_ce++;
    if (timeout_error) n_to++;
    if (32'(frame_valid) + 32'(crc_error) + 32'(timeout_error) > 1) n_multi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16_ref(input int n);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 7; k >= 0; k--) begin
        fb = r[15] ^ pl[i][k];
        r  = r << 1;
        if (fb) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, ".motor_id"},     32'(motor_id),     32'(exp_pl[0]));
    chk({tag, ".control_mode"}, 32'(control_mode), 32'(exp_pl[1]));
    chk({tag, ".enc0"},  {8'h00, encoder0_position}, {8'h00, exp_pl[2],  exp_pl[3],  exp_pl[4]});
    chk({tag, ".enc1"},  {8'h00, encoder1_position}, {8'h00, exp_pl[5],  exp_pl[6],  exp_pl[7]});
    chk({tag, ".setpt"}, {8'h00, setpoint_actual},   {8'h00, exp_pl[8],  exp_pl[9],  exp_pl[10]});
    chk({tag, ".duty"},  {8'h00, duty},              {8'h00, exp_pl[11], exp_pl[12], exp_pl[13]});
    chk({tag, ".disp"},  {8'h00, displacement},      {8'h00, exp_pl[14], exp_pl[15], exp_pl[16]});
    chk({tag, ".current"}, {16'h0000, current},      {16'h0000, exp_pl[17], exp_pl[18]});
    chk({tag, ".color"}, {8'h00, neopxl_color_actual}, {8'h00, exp_pl[19], exp_pl[20], exp_pl[21]});
    chk({tag, ".good_count"},    32'(good_count),    32'(exp_good));
    chk({tag, ".crc_err_count"}, 32'(crc_err_count), 32'(exp_crc));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 24; i++) exp_pl[i] = 8'h00;
    exp_good = 16'h0;
    exp_crc  = 16'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle, input logic ab);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b; abort = ab;
    @(negedge clk);
    rx_valid = 1'b0; abort = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic set_fixed_payload();
    logic [7:0] fixed [22];
    fixed = '{8'h03, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'hFF, 8'h80, 8'h00};
    for (int i = 0; i < 22; i++) pl[i] = fixed[i];
  endtask

  // Sends magic + pl; the last byte may carry abort; optionally pushes a byte during CHECK.
  task automatic send_frame(input string tag, input bit corrupt, input bit do_abort,
                            input int max_gap, input bit inject);
    logic [15:0] c;
    logic [31:0] magic;
    bit          good;
    magic = 32'h1CEB00DA;
    c = crc16_ref(22);
    pl[22] = c[15:8];
    pl[23] = c[7:0] ^ (corrupt ? 8'h01 : 8'h00);
    for (int i = 3; i >= 0; i--) send_byte(magic[i*8 +: 8], $urandom_range(max_gap, 0), 1'b0);
    for (int i = 0; i < 23; i++) send_byte(pl[i], $urandom_range(max_gap, 0), 1'b0);
    send_byte(pl[23], 0, do_abort);
    if (do_abort) begin
      chk({tag, ".abort_busy"}, 32'(busy), 0);
      chk({tag, ".abort_pulse1"}, {29'h0, frame_valid, crc_error, timeout_error}, 0);
      @(negedge clk);
      chk({tag, ".abort_pulse2"}, {29'h0, frame_valid, crc_error, timeout_error}, 0);
      chk_outputs({tag, ".abort"});
    end else begin
      chk({tag, ".check_busy"}, 32'(busy), 1);
      chk({tag, ".early_pulse"}, {29'h0, frame_valid, crc_error, timeout_error}, 0);
      if (inject) begin
        rx_valid = 1'b1; rx_data = 8'h1C;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      good = !corrupt;
      if (good) begin
        for (int i = 0; i < 24; i++) exp_pl[i] = pl[i];
        exp_good = exp_good + 16'd1;
        total_good++;
      end else begin
        exp_crc = exp_crc + 16'd1;
      end
      chk({tag, ".pulse"}, {29'h0, frame_valid, crc_error, timeout_error},
          good ? 32'h4 : 32'h2);
      chk_outputs(tag);
      @(negedge clk);
      chk({tag, ".pulse_width"}, {29'h0, frame_valid, crc_error, timeout_error}, 0);
      chk({tag, ".idle_busy"}, 32'(busy), 0);
      if (inject) begin
        send_byte(8'hEB, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hDA, 0, 1'b0);
        chk({tag, ".check_drop_busy"}, 32'(busy), 0);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".pulses"}, {29'h0, frame_valid, crc_error, timeout_error}, 0);
    chk_outputs(tag);
  endtask

  initial begin
    int fv0, to0;
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; abort = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    set_fixed_payload();
    send_frame("t1_good", 1'b0, 1'b0, 2, 1'b0);
    chk("t1.motor_id_lit", 32'(motor_id), 32'h03);
    chk("t1.enc0_lit", {8'h00, encoder0_position}, 32'h000102);
    chk("t1.good_lit", 32'(good_count), 1);

    set_fixed_payload();
    send_frame("t2_crc", 1'b1, 1'b0, 2, 1'b0);
    chk("t2.crc_err_lit", 32'(crc_err_count), 1);

    fv0 = n_fv;
    send_byte(8'h1C, 0, 1'b0);
    send_byte(8'hEB, 0, 1'b0);
    for (int i = 0; i < 22; i++) pl[i] = 8'($urandom_range(255, 0));
    send_frame("t3_overlap", 1'b0, 1'b0, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("t3.one_frame", 32'(n_fv - fv0), 1);

    to0 = n_to;
    send_byte(8'h1C, 0, 1'b0); send_byte(8'hEB, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0); send_byte(8'hDA, 0, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(255, 0)), 0, 1'b0);
    repeat (900) @(negedge clk);
    chk("t4.no_early_timeout", 32'(n_to - to0), 0);
    chk("t4.busy_waiting", 32'(busy), 1);
    repeat (200) @(negedge clk);
    chk("t4.timeout_seen", 32'(n_to - to0), 1);
    check_idle_outputs("t4.after");
    for (int i = 0; i < 22; i++) pl[i] = 8'($urandom_range(255, 0));
    send_frame("t4_next", 1'b0, 1'b0, 3, 1'b0);

    for (int i = 0; i < 22; i++) pl[i] = 8'($urandom_range(255, 0));
    pl[4] = 8'h1C; pl[5] = 8'hEB; pl[6] = 8'h00; pl[7] = 8'hDA;
    send_frame("t5_magic_in_payload", 1'b0, 1'b0, 1, 1'b0);

    for (int i = 0; i < 22; i++) pl[i] = 8'($urandom_range(255, 0));
    send_frame("t6_abort", 1'b0, 1'b1, 1, 1'b0);

    send_byte(8'h1C, 0, 1'b0); send_byte(8'hEB, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0); send_byte(8'hDA, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(255, 0)), 0, 1'b0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_idle_outputs("t6_reset_mid");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] nb;
      bit         corrupt, ab, inj;
      for (int k = $urandom_range(3, 0); k > 0; k--) begin
        nb = 8'($urandom_range(255, 0));
        if (nb == 8'h1C) nb = 8'h1D;
        send_byte(nb, $urandom_range(2, 0), 1'b0);
      end
      for (int i = 0; i < 22; i++) pl[i] = 8'($urandom_range(255, 0));
      corrupt = ($urandom_range(3, 0) == 0);
      ab      = ($urandom_range(7, 0) == 0);
      inj     = !ab && ($urandom_range(4, 0) == 0);
      send_frame($sformatf("rnd%0d", n), corrupt, ab, 4, inj);
    end

    repeat (3) @(negedge clk);
    chk("pulses_exclusive", 32'(n_multi), 0);
    chk("total_good_pulses", 32'(n_fv), 32'(total_good));
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
